// File: rtl/imem_fetch_resp_pkg.sv
// Shared types and constants for the instruction fetch responder.
package imem_fetch_resp_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;   // addi x0,x0,0

    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/imem_fetch_resp_fetch_fifo.sv
// In-order response buffer with synchronous clear; pointers wrap at DEPTH-1
// so DEPTH does not have to be a power of two.
module fetch_fifo
    import imem_fetch_resp_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = ENTRY_W,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_resp.sv
// Fetch responder: credit-limited request acceptance, one in-flight memory
// read, and an in-order response FIFO toward decode.
module imem_fetch_resp
    import imem_fetch_resp_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ROM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    output logic              req_ready,
    output logic              mem_en,
    output logic [ROM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_pc,
    output logic [31:0]       resp_instr,
    output logic              resp_err,
    input  logic              resp_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          inflight;
    logic [31:0]   ifl_pc;
    logic          ifl_err;
    logic          accept;
    logic          pop;
    logic          push;
    logic [CW-1:0] count;
    logic [CW:0]   occ_after_pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // Handshakes: a transfer happens on a cycle where valid & ready are both
    // high; valid never depends on ready, and ready may depend on valid/flush
    // combinationally (req_ready sees resp_ready through the same-cycle pop).
    assign pop           = resp_valid & resp_ready & ~flush;
    assign occ_after_pop = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    assign req_ready     = ~flush & (occ_after_pop < (CW+1)'(DEPTH));
    assign accept        = req_valid & req_ready;

    // Misaligned fetches skip memory but still take the in-flight slot.
    assign mem_en   = accept & ~is_misaligned(req_addr);
    assign mem_addr = req_addr[ROM_AW+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
            ifl_pc   <= ZERO_WORD;
            ifl_err  <= 1'b0;
        end else if (flush) begin
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                ifl_pc  <= req_addr;
                ifl_err <= is_misaligned(req_addr);
            end
        end
    end

    assign push             = inflight & ~flush;
    assign push_entry.err   = ifl_err;
    assign push_entry.pc    = ifl_pc;
    assign push_entry.instr = ifl_err ? NOP_INST : mem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (count)
    );

    assign resp_valid = (count != '0);
    assign resp_pc    = head_entry.pc;
    assign resp_instr = head_entry.instr;
    assign resp_err   = head_entry.err;

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Scoreboard bench for imem_fetch_resp: directed scenarios followed by a
// random valid/ready/flush soak against a queue-based reference model.
module tb_imem_fetch_resp;

    localparam int DEPTH  = 2;
    localparam int ROM_AW = 10;
    localparam int EW     = 97;   // {cyc[31:0], err, pc[31:0], instr[31:0]}

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              req_valid;
    logic [31:0]       req_addr;
    logic              req_ready;
    logic              mem_en;
    logic [ROM_AW-1:0] mem_addr;
    logic [31:0]       mem_rdata = 32'h0;
    logic              resp_valid;
    logic [31:0]       resp_pc;
    logic [31:0]       resp_instr;
    logic              resp_err;
    logic              resp_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [EW-1:0] exp_q[$];

    imem_fetch_resp #(.DEPTH(DEPTH), .ROM_AW(ROM_AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_pc    (resp_pc),
        .resp_instr (resp_instr),
        .resp_err   (resp_err),
        .resp_ready (resp_ready)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return {a, 6'h2A, ~a, 6'h15};
    endfunction

    always @(posedge clk) if (mem_en) mem_rdata <= rom_word(mem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic          m_valid, m_ready, m_pop, m_acc, m_mis;
    logic [EW-1:0] m_head;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_resp_pc",    64'(resp_pc),    64'd0);
            chk("rst_resp_instr", 64'(resp_instr), 64'd0);
            chk("rst_resp_err",   64'(resp_err),   64'd0);
        end else begin
            m_head  = (exp_q.size() > 0) ? exp_q[0] : '0;
            m_valid = (exp_q.size() > 0) && (cyc >= int'(m_head[96:65]) + 2);
            m_pop   = m_valid & resp_ready & ~flush;
            m_ready = !flush && ((exp_q.size() - int'(m_pop)) < DEPTH);
            m_acc   = req_valid & m_ready;
            m_mis   = (req_addr[1:0] != 2'b00);

            chk("resp_valid", 64'(resp_valid), 64'(m_valid));
            if (m_valid) begin
                chk("resp_err",   64'(resp_err),   64'(m_head[64]));
                chk("resp_pc",    64'(resp_pc),    64'(m_head[63:32]));
                chk("resp_instr", 64'(resp_instr), 64'(m_head[31:0]));
            end
            chk("req_ready", 64'(req_ready), 64'(m_ready));
            chk("mem_en", 64'(mem_en), 64'(m_acc & ~m_mis));
            if (m_acc && !m_mis) chk("mem_addr", 64'(mem_addr), 64'(req_addr[11:2]));

            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (m_acc)
                    exp_q.push_back({32'(cyc), m_mis, req_addr,
                                     m_mis ? 32'h0000_0013 : rom_word(req_addr[11:2])});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step(input logic v, input logic [31:0] a, input logic rr, input logic fl);
        req_valid  = v;
        req_addr   = a;
        resp_ready = rr;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic mid_reset();
        req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("async_rst_resp_pc",    64'(resp_pc),    64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // back-to-back aligned fetches
        step(1, 32'h0000_0000, 1, 0);
        step(1, 32'h0000_0004, 1, 0);
        step(1, 32'h0000_0008, 1, 0);
        idle(4);

        // backpressure: credits cap accepts, then drain in order
        for (int i = 0; i < 6; i++) step(1, 32'h100 + 32'(i * 4), 0, 0);
        for (int i = 0; i < 6; i++) step(1, 32'h200 + 32'(i * 4), 1, 0);
        idle(4);

        // misaligned fetch between aligned neighbours
        step(1, 32'h0000_0004, 1, 0);
        step(1, 32'h0000_0006, 1, 0);
        step(1, 32'h0000_0008, 1, 0);
        idle(4);

        // flush with 0x0C buffered and 0x10 in flight
        step(1, 32'h0000_000C, 0, 0);
        step(1, 32'h0000_0010, 0, 0);
        step(0, 32'h0000_0000, 0, 1);
        step(1, 32'h0000_0040, 1, 0);
        idle(4);
        step(0, 32'h0, 1, 1);
        step(0, 32'h0, 1, 1);
        idle(2);

        // asynchronous reset with two entries buffered
        step(1, 32'h0000_0300, 0, 0);
        step(1, 32'h0000_0304, 0, 0);
        step(0, 32'h0, 0, 0);
        mid_reset();
        step(1, 32'h0000_0400, 1, 0);
        idle(4);

        // random soak
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0);
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
